// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DBG  = 1'b1;

   // Latency counter width; covers MEM_LAT up to 4.
   localparam int LAT_W = 2;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the requester that did not win last gets the tie.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic       i_upd,
   output logic [1:0] o_gnt
);

   logic r_last;

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = (r_last == REQ_DBG) ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last <= REQ_DBG;
      end else if (i_upd && (|i_req)) begin
         r_last <= o_gnt[1] ? REQ_DBG : REQ_CORE;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core load/store path and a
// debug host port, one access at a time, and stalls the core while it waits.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_re,
   output logic              m_we,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              core_stall,
   output logic              busy
);

   state_t              r_state;
   state_t              w_next;
   logic                r_owner;
   logic                r_we;
   logic [LAT_W-1:0]    r_lat;
   logic                r_mre;
   logic                r_mwe;
   logic [ADDR_W-1:0]   r_maddr;
   logic [DATA_W-1:0]   r_mwdata;
   logic [DATA_W-1:0]   r_crdata;
   logic [DATA_W-1:0]   r_drdata;
   logic                r_crvalid;
   logic                r_drvalid;

   logic [1:0]          w_arb_gnt;
   logic                w_grant_en;
   logic                w_grant;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_last_wait;
   logic                w_core_pend;

   rr_arb2 u_rr (
      .clk   (clk),
      .reset (reset),
      .i_req ({d_req, c_req}),
      .i_upd (w_grant),
      .o_gnt (w_arb_gnt)
   );

   // Grants are combinational and gated by reset so every output is 0 in reset.
   assign w_grant_en  = reset & (r_state == IDLE);
   assign c_gnt       = w_grant_en & w_arb_gnt[0];
   assign d_gnt       = w_grant_en & w_arb_gnt[1];
   assign w_grant     = c_gnt | d_gnt;

   assign w_sel_we    = d_gnt ? d_we    : c_we;
   assign w_sel_addr  = d_gnt ? d_addr  : c_addr;
   assign w_sel_wdata = d_gnt ? d_wdata : c_wdata;

   assign w_last_wait = (r_state == WAIT) && (r_lat == LAT_W'(MEM_LAT - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_next = ISSUE;
         ISSUE:   w_next = r_we ? IDLE : WAIT;
         WAIT:    if (w_last_wait) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner   <= REQ_CORE;
         r_we      <= 1'b0;
         r_lat     <= '0;
         r_mre     <= 1'b0;
         r_mwe     <= 1'b0;
         r_maddr   <= '0;
         r_mwdata  <= '0;
         r_crdata  <= '0;
         r_drdata  <= '0;
         r_crvalid <= 1'b0;
         r_drvalid <= 1'b0;
      end else begin
         // A grant only happens in IDLE, so the strobes are high only in ISSUE.
         r_mre <= w_grant & ~w_sel_we;
         r_mwe <= w_grant &  w_sel_we;
         if (w_grant) begin
            r_owner  <= d_gnt ? REQ_DBG : REQ_CORE;
            r_we     <= w_sel_we;
            r_maddr  <= w_sel_addr;
            r_mwdata <= w_sel_wdata;
         end
         r_lat     <= (r_state == WAIT) ? r_lat + 1'b1 : '0;
         r_crvalid <= w_last_wait & (r_owner == REQ_CORE);
         r_drvalid <= w_last_wait & (r_owner == REQ_DBG);
         if (w_last_wait && (r_owner == REQ_CORE)) r_crdata <= m_rdata;
         if (w_last_wait && (r_owner == REQ_DBG))  r_drdata <= m_rdata;
      end
   end

   assign m_re     = r_mre;
   assign m_we     = r_mwe;
   assign m_addr   = r_maddr;
   assign m_wdata  = r_mwdata;
   assign c_rvalid = r_crvalid;
   assign d_rvalid = r_drvalid;
   assign c_rdata  = r_crdata;
   assign d_rdata  = r_drdata;
   assign busy     = (r_state != IDLE);

   // A pending core load stalls from its grant cycle; the response cycle releases
   // the core even if it still holds c_req, and a posted write stalls in ISSUE only.
   assign w_core_pend = (r_owner == REQ_CORE) && ((r_state == ISSUE) || (r_state == WAIT));
   assign core_stall  = reset & ((c_req & ~r_crvalid & ~(c_gnt & c_we)) | w_core_pend);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed corner sequences, a transaction
// table and a randomized run against a cycle-formula reference model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
   logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
   logic        m_re, m_we, core_stall, busy;

   logic        c3_req, c3_we, d3_req, d3_we;
   logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
   logic        c3_gnt, c3_rvalid, d3_gnt, d3_rvalid;
   logic [31:0] c3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata;
   logic        m3_re, m3_we, stall3, busy3;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we),
      .m_rdata(m_rdata), .core_stall(core_stall), .busy(busy)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .c_req(c3_req), .c_we(c3_we), .c_addr(c3_addr), .c_wdata(c3_wdata),
      .c_gnt(c3_gnt), .c_rvalid(c3_rvalid), .c_rdata(c3_rdata),
      .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
      .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
      .m_addr(m3_addr), .m_wdata(m3_wdata), .m_re(m3_re), .m_we(m3_we),
      .m_rdata(m3_rdata), .core_stall(stall3), .busy(busy3)
   );

   // Memory model: preloaded pattern until written; reads return garbage when not due.
   function automatic logic [31:0] init_val(input logic [7:0] a);
      if (a == 8'h10) return 32'hDEADBEEF;
      if (a == 8'h24) return 32'h0BADF00D;
      return {24'hC0FFEE, a};
   endfunction

   logic [31:0] mem [0:255];
   bit          wr  [0:255];
   bit          vp  [0:3];
   bit          vp3 [0:3];
   logic [7:0]  ap  [0:3];
   logic [7:0]  ap3 [0:3];

   always @(posedge clk) begin
      if (m_we) begin
         mem[m_addr[7:0]] <= m_wdata;
         wr[m_addr[7:0]]  <= 1'b1;
      end
      vp[0]  <= m_re;   ap[0]  <= m_addr[7:0];
      vp3[0] <= m3_re;  ap3[0] <= m3_addr[7:0];
      for (int k = 1; k < 4; k++) begin
         vp[k]  <= vp[k-1];  ap[k]  <= ap[k-1];
         vp3[k] <= vp3[k-1]; ap3[k] <= ap3[k-1];
      end
   end

   always_comb begin
      m_rdata = 32'hBAD0BAD0;
      if (vp[0]) m_rdata = wr[ap[0]] ? mem[ap[0]] : init_val(ap[0]);
   end

   always_comb begin
      m3_rdata = 32'hBAD0BAD0;
      if (vp3[2]) m3_rdata = wr[ap3[2]] ? mem[ap3[2]] : init_val(ap3[2]);
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic rst_outs(input string tag);
      chk({tag, " m_addr"},  m_addr,  32'h0);
      chk({tag, " m_wdata"}, m_wdata, 32'h0);
      chk({tag, " c_rdata"}, c_rdata, 32'h0);
      chk({tag, " d_rdata"}, d_rdata, 32'h0);
      chk({tag, " ctrl"}, 32'({c_gnt, d_gnt, c_rvalid, d_rvalid, m_re, m_we, core_stall, busy}), 32'h0);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 20; k++) begin
         if (!busy) break;
         nxt(); smp();
      end
      chk1("idle reached", busy, 1'b0);
   endtask

   // One access on one requester; starts and ends at a negedge.
   task automatic xact(input logic dbg, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd);
      bit got;
      got = 0;
      rd  = '0;
      nxt();
      if (dbg) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
      else     begin c_req = 1; c_we = we; c_addr = a; c_wdata = wd; end
      for (int k = 0; k < 20; k++) begin
         smp();
         if (dbg ? d_gnt : c_gnt) begin got = 1; break; end
         nxt();
      end
      chk1("xact grant", got, 1'b1);
      nxt();
      if (dbg) d_req = 0; else c_req = 0;
      smp();
      if (!we) begin
         got = 0;
         for (int k = 0; k < 20; k++) begin
            if (dbg ? d_rvalid : c_rvalid) begin got = 1; rd = dbg ? d_rdata : c_rdata; break; end
            nxt(); smp();
         end
         chk1("xact rvalid", got, 1'b1);
      end
      wait_idle();
   endtask

   typedef struct {
      logic        creq;
      logic        dreq;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  egnt;
      logic [31:0] erdata;
   } vec_t;

   vec_t tbl [9];

   initial begin
      automatic logic [31:0] rd;
      automatic logic [1:0]  seq [4];
      automatic int          ng = 0;
      automatic logic [31:0] dseen;
      automatic logic [31:0] rmem [0:7];
      automatic bit          pv = 0, pwe = 0, pown = 0, last_dbg = 0;
      automatic int          pt = 0, free_at = 0, idx = 0;
      automatic logic [31:0] paddr = 0, pwd = 0, prd = 0, c_mod, d_mod;
      automatic bit          idle, egc, egd, ere, ewe, ecv, edv, ebusy, estall;
      automatic bit          got;
      const int L = 1;

      // Transaction table; the round-robin pointer starts with "core was last".
      tbl[0] = '{1, 1, 0, 32'h10, 32'h0,        2'b10, 32'hDEADBEEF};
      tbl[1] = '{1, 1, 0, 32'h24, 32'h0,        2'b01, 32'h0BADF00D};
      tbl[2] = '{1, 0, 1, 32'h40, 32'h11111111, 2'b01, 32'h0};
      tbl[3] = '{1, 1, 0, 32'h40, 32'h0,        2'b10, 32'h11111111};
      tbl[4] = '{0, 1, 1, 32'h44, 32'h22222222, 2'b10, 32'h0};
      tbl[5] = '{1, 1, 0, 32'h44, 32'h0,        2'b01, 32'h22222222};
      tbl[6] = '{0, 1, 0, 32'h10, 32'h0,        2'b10, 32'hDEADBEEF};
      tbl[7] = '{1, 1, 1, 32'h48, 32'h33333333, 2'b01, 32'h0};
      tbl[8] = '{1, 0, 0, 32'h48, 32'h0,        2'b01, 32'h33333333};

      c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
      d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
      reset = 1;
      #2 reset = 0;
      #1 rst_outs("reset");
      repeat (2) @(negedge clk);
      reset = 1;

      // Core read of preloaded 0x10, cycle by cycle.
      nxt(); c_req = 1; c_we = 0; c_addr = 32'h10;
      smp(); chk1("t1 c_gnt@T", c_gnt, 1); chk1("t1 stall@T", core_stall, 1);
      nxt(); c_req = 0;
      smp(); chk1("t1 m_re@T+1", m_re, 1); chk("t1 m_addr@T+1", m_addr, 32'h10);
             chk1("t1 m_we@T+1", m_we, 0); chk1("t1 stall@T+1", core_stall, 1);
      nxt(); smp(); chk1("t1 m_re@T+2", m_re, 0); chk1("t1 stall@T+2", core_stall, 1);
             chk1("t1 rvalid@T+2", c_rvalid, 0);
      nxt(); smp(); chk1("t1 rvalid@T+3", c_rvalid, 1); chk("t1 rdata@T+3", c_rdata, 32'hDEADBEEF);
             chk1("t1 stall@T+3", core_stall, 0); chk1("t1 d_rvalid@T+3", d_rvalid, 0);
      nxt(); smp(); chk1("t1 busy@T+4", busy, 0); chk1("t1 rvalid@T+4", c_rvalid, 0);

      // Debug write then read back.
      nxt(); d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
      smp(); chk1("t2 d_gnt", d_gnt, 1);
      nxt(); d_req = 0;
      smp(); chk1("t2 m_we@T+1", m_we, 1); chk("t2 m_wdata", m_wdata, 32'h12345678);
             chk("t2 m_addr", m_addr, 32'h20); chk1("t2 m_re@T+1", m_re, 0);
      nxt(); smp(); chk1("t2 m_we@T+2", m_we, 0); chk1("t2 busy@T+2", busy, 0);
      xact(1, 0, 32'h20, 32'h0, rd);
      chk("t2 readback", rd, 32'h12345678);

      // Both requesting continuously: grants alternate starting with the core.
      dseen = 32'h12345678;
      nxt(); c_req = 1; d_req = 1; c_we = 0; d_we = 0; c_addr = 32'h10; d_addr = 32'h24;
      for (int i = 0; i < 4; i++) seq[i] = 2'b00;
      for (int k = 0; k < 40; k++) begin
         smp();
         if ((c_gnt || d_gnt) && ng < 4) begin seq[ng] = {d_gnt, c_gnt}; ng++; end
         if (c_rvalid) begin
            chk("rr c_rdata", c_rdata, 32'hDEADBEEF);
            chk("rr d_rdata hold", d_rdata, dseen);
            chk1("rr d_rvalid with core", d_rvalid, 0);
         end
         if (d_rvalid) begin
            chk("rr d_rdata", d_rdata, 32'h0BADF00D);
            chk1("rr c_rvalid with dbg", c_rvalid, 0);
            dseen = 32'h0BADF00D;
         end
         nxt();
         if (ng >= 4) begin c_req = 0; d_req = 0; end
      end
      smp();
      for (int i = 0; i < 4; i++) chk("rr order", 32'(seq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      wait_idle();

      // Core arrives while a debug read is in WAIT.
      nxt(); d_req = 1; d_we = 0; d_addr = 32'h20;
      smp(); chk1("t4 d_gnt", d_gnt, 1);
      nxt(); d_req = 0; smp();
      nxt(); c_req = 1; c_we = 0; c_addr = 32'h10;
      smp(); chk1("t4 c_gnt WAIT", c_gnt, 0); chk1("t4 stall WAIT", core_stall, 1); chk1("t4 busy WAIT", busy, 1);
      nxt(); smp(); chk1("t4 d_rvalid", d_rvalid, 1); chk1("t4 c_gnt RESP", c_gnt, 0);
             chk1("t4 stall RESP", core_stall, 1);
      nxt(); smp(); chk1("t4 c_gnt IDLE", c_gnt, 1); chk1("t4 busy IDLE", busy, 0);
             chk1("t4 stall IDLE", core_stall, 1);
      nxt(); c_req = 0; smp();
      got = 0;
      for (int k = 0; k < 10; k++) begin
         if (c_rvalid) begin got = 1; chk("t4 c_rdata", c_rdata, 32'hDEADBEEF); end
         if (!busy) break;
         nxt(); smp();
      end
      chk1("t4 c_rvalid seen", got, 1);

      // MEM_LAT=3 instance.
      nxt(); c3_req = 1; c3_we = 0; c3_addr = 32'h10;
      smp(); chk1("lat3 gnt", c3_gnt, 1);
      for (int k = 1; k <= 6; k++) begin
         nxt();
         if (k == 1) c3_req = 0;
         smp();
         chk1("lat3 m_re", m3_re, k == 1);
         chk1("lat3 rvalid", c3_rvalid, k == 5);
         chk1("lat3 busy", busy3, k < 6);
         if (k == 5) chk("lat3 rdata", c3_rdata, 32'hDEADBEEF);
      end

      // Reset asserted during WAIT of a core read.
      nxt(); c_req = 1; c_we = 0; c_addr = 32'h10;
      smp(); chk1("t6 c_gnt", c_gnt, 1);
      nxt(); c_req = 0; smp();
      nxt();
      reset = 0;
      #1 rst_outs("mid-op reset");
      for (int k = 0; k < 3; k++) begin
         smp(); chk1("t6 no rvalid", c_rvalid, 0);
         nxt();
      end
      smp(); reset = 1;
      nxt(); c_req = 1; d_req = 1; c_we = 0; d_we = 0; c_addr = 32'h24; d_addr = 32'h10;
      smp(); chk1("t6 c_gnt after reset", c_gnt, 1); chk1("t6 d_gnt after reset", d_gnt, 0);
      nxt(); c_req = 0; d_req = 0; smp();
      got = 0;
      for (int k = 0; k < 10; k++) begin
         if (c_rvalid) begin got = 1; chk("t6 c_rdata", c_rdata, 32'h0BADF00D); end
         if (!busy) break;
         nxt(); smp();
      end
      chk1("t6 c_rvalid seen", got, 1);

      // Transaction table.
      foreach (tbl[i]) begin
         nxt();
         c_req = tbl[i].creq; d_req = tbl[i].dreq; c_we = tbl[i].we; d_we = tbl[i].we;
         c_addr = tbl[i].addr; d_addr = tbl[i].addr; c_wdata = tbl[i].wdata; d_wdata = tbl[i].wdata;
         smp(); chk("tbl gnt", 32'({d_gnt, c_gnt}), 32'(tbl[i].egnt));
         nxt(); c_req = 0; d_req = 0; smp();
         if (!tbl[i].we) begin
            for (int k = 0; k < 12; k++) begin
               if (c_rvalid || d_rvalid) break;
               nxt(); smp();
            end
            chk("tbl rvalid owner", 32'({d_rvalid, c_rvalid}), 32'(tbl[i].egnt));
            chk("tbl rdata", tbl[i].egnt[0] ? c_rdata : d_rdata, tbl[i].erdata);
         end
         wait_idle();
      end

      // Randomized traffic against the reference model.
      for (int k = 0; k < 8; k++) rmem[k] = init_val(8'(8'h80 + 4 * k));
      c_mod = 32'h33333333;
      d_mod = 32'hDEADBEEF;
      last_dbg = 0;
      for (int i = 0; i < 250; i++) begin
         nxt();
         c_req = ($urandom_range(0, 3) != 0); c_we = $urandom_range(0, 1) != 0;
         d_req = ($urandom_range(0, 3) != 0); d_we = $urandom_range(0, 1) != 0;
         c_addr = 32'h80 + 32'(4 * $urandom_range(0, 7)); c_wdata = $urandom;
         d_addr = 32'h80 + 32'(4 * $urandom_range(0, 7)); d_wdata = $urandom;
         smp();
         idle  = !pv || (i >= free_at);
         egc   = idle && c_req && (!d_req || last_dbg);
         egd   = idle && d_req && (!c_req || !last_dbg);
         ere   = pv && !pwe && (i == pt + 1);
         ewe   = pv &&  pwe && (i == pt + 1);
         ecv   = pv && !pwe && !pown && (i == pt + 2 + L);
         edv   = pv && !pwe &&  pown && (i == pt + 2 + L);
         ebusy = pv && (i > pt) && (i < free_at);
         estall = (c_req && !ecv && !(egc && c_we)) ||
                  (pv && !pown && (i > pt) && (i < (pwe ? pt + 2 : pt + 2 + L)));
         if (ecv) c_mod = prd;
         if (edv) d_mod = prd;
         chk("rnd gnt", 32'({d_gnt, c_gnt}), 32'({egd, egc}));
         chk("rnd strobes", 32'({m_we, m_re}), 32'({ewe, ere}));
         chk("rnd rvalid", 32'({d_rvalid, c_rvalid}), 32'({edv, ecv}));
         chk1("rnd busy", busy, ebusy);
         chk1("rnd stall", core_stall, estall);
         chk("rnd c_rdata", c_rdata, c_mod);
         chk("rnd d_rdata", d_rdata, d_mod);
         if (ere || ewe) chk("rnd m_addr", m_addr, paddr);
         if (ewe) chk("rnd m_wdata", m_wdata, pwd);
         if (egc || egd) begin
            pv = 1; pt = i; pown = egd; last_dbg = egd;
            pwe   = egd ? d_we : c_we;
            paddr = egd ? d_addr : c_addr;
            pwd   = egd ? d_wdata : c_wdata;
            free_at = i + (pwe ? 2 : 3 + L);
            idx = int'((paddr - 32'h80) >> 2);
            if (pwe) rmem[idx] = pwd;
            else     prd = rmem[idx];
         end
      end
      nxt(); c_req = 0; d_req = 0; smp();
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
